// File: rtl/luma_palette_feed.sv
// Luma extractor and palette selector feeding a colouriser, with matched sync delays.
// Optional LUMA_FEED_BLANK_EN forces luma to 0 outside active video.
`timescale 1ns/1ps

module luma_palette_feed #(
  parameter int SYNC_DLY  = 4,
  parameter int MODE_LAST = 15
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic [23:0] vid_pData_in,
  input  logic        vid_pVDE,
  input  logic        vid_pHSync,
  input  logic        vid_pVSync,
  input  logic [3:0]  mode_in,
  input  logic        auto_en,
  input  logic [7:0]  hold_frames,
  output logic [7:0]  luma_out,
  output logic [3:0]  mode_out,
  output logic        vid_pVDE_out,
  output logic        vid_pHSync_out,
  output logic        vid_pVSync_out
);

  localparam logic [3:0] MODE_LAST_L = 4'(MODE_LAST);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  // luma pipeline
  logic [15:0] prod_r_d, prod_g_d, prod_b_d;
  logic [15:0] prod_r_q, prod_g_q, prod_b_q;
  logic [15:0] sum_d, sum_q;
  logic [7:0]  luma_d, luma_q;

  // sync delay lines, bit order {vde, hsync, vsync}
  logic [SYNC_DLY-1:0][2:0] sync_sr_d, sync_sr_q;

  // palette control
  state_t      state_d, state_q;
  logic [7:0]  fcnt_d, fcnt_q;
  logic [3:0]  mode_d, mode_q;
  logic [3:0]  mode_next;
  logic        vs_prev_d, vs_prev_q;
  logic        vs_rise;

`ifdef LUMA_FEED_BLANK_EN
  logic [1:0] vde_blk_d, vde_blk_q;
`endif

  always_comb begin
    prod_r_d = 16'(vid_pData_in[23:16]) * 16'd77;
    prod_g_d = 16'(vid_pData_in[15:8])  * 16'd150;
    prod_b_d = 16'(vid_pData_in[7:0])   * 16'd29;
    // weights sum to 256, so the sum tops out at 65280 and never wraps
    sum_d    = prod_r_q + prod_g_q + prod_b_q;
    luma_d   = sum_q[15:8];
`ifdef LUMA_FEED_BLANK_EN
    vde_blk_d = {vde_blk_q[0], vid_pVDE};
    if (!vde_blk_q[1]) begin
      luma_d = 8'd0;
    end
`endif
  end

  always_comb begin
    sync_sr_d[0] = {vid_pVDE, vid_pHSync, vid_pVSync};
    for (int i = 1; i < SYNC_DLY; i++) begin
      sync_sr_d[i] = sync_sr_q[i-1];
    end
  end

  assign vs_prev_d = vid_pVSync;
  assign vs_rise   = vid_pVSync & ~vs_prev_q;
  assign mode_next = (mode_q >= MODE_LAST_L) ? 4'd0 : mode_q + 4'd1;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_MANUAL: begin
        if (vs_rise) begin
          mode_d = mode_in;
          fcnt_d = 8'd0;
        end
        if (auto_en) begin
          state_d = ST_AUTO;
          fcnt_d  = 8'd0;
        end
      end
      ST_AUTO: begin
        if (!auto_en) begin
          // dropping out of auto on a frame edge still loads the manual palette
          state_d = ST_MANUAL;
          if (vs_rise) begin
            mode_d = mode_in;
            fcnt_d = 8'd0;
          end
        end else if (vs_rise) begin
          if (fcnt_q >= hold_frames) begin
            mode_d = mode_next;
            fcnt_d = 8'd0;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      prod_r_q  <= '0;
      prod_g_q  <= '0;
      prod_b_q  <= '0;
      sum_q     <= '0;
      luma_q    <= '0;
      sync_sr_q <= '0;
      state_q   <= ST_MANUAL;
      fcnt_q    <= '0;
      mode_q    <= '0;
      vs_prev_q <= 1'b0;
`ifdef LUMA_FEED_BLANK_EN
      vde_blk_q <= '0;
`endif
    end else begin
      prod_r_q  <= prod_r_d;
      prod_g_q  <= prod_g_d;
      prod_b_q  <= prod_b_d;
      sum_q     <= sum_d;
      luma_q    <= luma_d;
      sync_sr_q <= sync_sr_d;
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      mode_q    <= mode_d;
      vs_prev_q <= vs_prev_d;
`ifdef LUMA_FEED_BLANK_EN
      vde_blk_q <= vde_blk_d;
`endif
    end
  end

  assign luma_out       = luma_q;
  assign mode_out       = mode_q;
  assign vid_pVDE_out   = sync_sr_q[SYNC_DLY-1][2];
  assign vid_pHSync_out = sync_sr_q[SYNC_DLY-1][1];
  assign vid_pVSync_out = sync_sr_q[SYNC_DLY-1][0];

endmodule

// File: doc/luma_palette_feed.md
LUMA_PALETTE_FEED -- requirements
Module: luma_palette_feed

Interface
REQ-001 Parameter SYNC_DLY, default 4, sync/DE delay in pixclk cycles: 3-cycle luma pipeline plus 1-cycle downstream palette ROM.
REQ-002 Parameter MODE_LAST, default 15, highest palette index reached before auto-cycle wraps to 0.
REQ-003 pixclk  in  1  pixel clock; the only clock, all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 vid_pData_in  in  24  RGB pixel, {R[23:16], G[15:8], B[7:0]}.
REQ-006 vid_pVDE  in  1  active-video enable.
REQ-007 vid_pHSync  in  1  horizontal sync.
REQ-008 vid_pVSync  in  1  vertical sync, active-high; rising edge marks frame boundary.
REQ-009 mode_in  in  4  manual palette select.
REQ-010 auto_en  in  1  1 = automatic palette cycling.
REQ-011 hold_frames  in  8  frames per palette in auto mode.
REQ-012 luma_out  out  8  luma feeding the colouriser's luma input.
REQ-013 mode_out  out  4  palette select feeding the colouriser's mode input.
REQ-014 vid_pVDE_out, vid_pHSync_out, vid_pVSync_out  out  1 each  delayed controls, aligned with colouriser RGB output.

Function
REQ-015 Luma SHALL be (77*R + 150*G + 29*B) >> 8, unsigned, no rounding; weights sum to 256, so 0xFFFFFF yields 255.
REQ-016 Pipeline: stage 1 registers three 16-bit products; stage 2 registers their 16-bit sum, which cannot overflow (max 65280); stage 3 registers sum[15:8] to luma_out.
REQ-017 Latency is exactly 3 cycles, vid_pData_in to luma_out; the pipeline runs every cycle, with no stall or valid qualifier.
REQ-018 VDE, HSync and VSync SHALL each pass through a SYNC_DLY-stage shift register to their _out ports.
REQ-019 VSync rising edge is detected on the undelayed input: registered previous value low, current value high; this is one pulse per frame.
REQ-020 The palette FSM has two states, MANUAL and AUTO, plus an 8-bit frame counter fcnt.
REQ-021 MANUAL: on each VSync rising edge, mode_out <= mode_in and fcnt <= 0; between edges mode_out holds, so palettes never change mid-frame.
REQ-022 MANUAL -> AUTO when auto_en = 1; fcnt cleared; mode_out unchanged, so cycling starts from the current palette.
REQ-023 AUTO, on each VSync rising edge: if fcnt >= hold_frames, mode_out advances by 1 and fcnt <= 0; otherwise fcnt increments.
REQ-024 Advance rule: mode_out == MODE_LAST or greater wraps to 0.
REQ-025 hold_frames = 0 SHALL advance the palette on every frame.
REQ-026 AUTO -> MANUAL when auto_en = 0.
REQ-027 auto_en falling in the same cycle as a VSync rising edge: the MANUAL rule applies, mode_out <= mode_in.
REQ-028 hold_frames changing mid-count takes effect at the next comparison; fcnt never exceeds 255.

Reset
REQ-029 rst asserted: luma_out = 0, mode_out = 0, all pipeline and delay stages = 0, all _out syncs = 0, fcnt = 0, FSM = MANUAL, edge-detect register = 0.
REQ-030 Reset mid-frame discards in-flight pixels; first valid luma appears 3 cycles after rst deasserts.
REQ-031 After reset, mode_out stays 0 until the first VSync rising edge.

Configuration
REQ-032 Macro LUMA_FEED_BLANK_EN: when defined, luma_out is forced to 0 whenever the stage-3-aligned VDE (3-cycle delayed) is 0, so blanking maps to palette entry 0.
REQ-033 When LUMA_FEED_BLANK_EN is undefined, luma_out follows REQ-015 regardless of VDE.

Verification
REQ-034 Reset, then pixels 0xFFFFFF, 0xFF0000, 0x00FF00, 0x0000FF on consecutive cycles -> luma_out 255, 76, 149, 28 on cycles 3-6 after the first pixel.
REQ-035 Drive VDE pulse 1 cycle high -> vid_pVDE_out high exactly 4 cycles later, for 1 cycle.
REQ-036 auto_en = 0, mode_in changed 3 -> 9 mid-frame -> mode_out stays at prior value until the next VSync rising edge, then reads 9.
REQ-037 auto_en = 1, hold_frames = 2, start mode 14, MODE_LAST = 15 -> mode_out 14, 15, 0 with a change every 3rd VSync rising edge.
REQ-038 auto_en 1 -> 0 in the same cycle as a VSync rising edge with mode_in = 5 -> mode_out = 5 next cycle; rst pulsed mid-frame -> mode_out = 0, luma_out = 0 immediately.
REQ-039 With LUMA_FEED_BLANK_EN defined, pixel 0xFFFFFF with VDE = 0 -> luma_out = 0; without the macro -> 255.
